// File: rtl/multiplay_mouse_acc.sv
//------------------------------------------------------------------------------
// Module      : multiplay_mouse_acc
// Description : Multiplay mouse register window for 1..2 PS/2 mice with signed
//               saturating per-axis accumulators and clamped per-read deltas.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multiplay_mouse_acc #(
    parameter int NCH   = 2,
    parameter int ACC_W = 10,
    parameter int CLAMP = 7
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [25*NCH-1:0]  ps2_mouse,
    input  logic               sel,
    input  logic [2:0]         addr,
    output logic [7:0]         dout
);

    localparam int c_aw2 = ACC_W + 2;
    localparam logic signed [c_aw2-1:0] c_clamp_hi = c_aw2'(CLAMP);
    localparam logic signed [c_aw2-1:0] c_clamp_lo = c_aw2'(-(CLAMP + 1));
    localparam logic signed [c_aw2-1:0] c_sat_hi   = c_aw2'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [c_aw2-1:0] c_sat_lo   = c_aw2'(-(1 << (ACC_W - 1)));

    logic signed [ACC_W-1:0] r_acc_x_q [NCH];
    logic signed [ACC_W-1:0] r_acc_y_q [NCH];
    logic signed [ACC_W-1:0] w_acc_x_d [NCH];
    logic signed [ACC_W-1:0] w_acc_y_d [NCH];
    logic [2:0]              r_btn_q   [NCH];
    logic [2:0]              w_btn_d   [NCH];
    logic [7:0]              w_out_x   [NCH];
    logic [7:0]              w_out_y   [NCH];
    logic [NCH-1:0]          r_old_tog_q;
    logic [NCH-1:0]          w_tog;
    logic [NCH-1:0]          w_pkt;
    logic                    r_old_sel_q;
    logic [7:0]              r_dout_q;
    logic [7:0]              w_dout_d;
    logic                    w_rd;
    logic [2:0]              w_btn1;
    logic [7:0]              w_x1;
    logic [7:0]              w_y1;
    logic                    w_unused;

    logic signed [c_aw2-1:0] w_dx, w_dy, w_ax, w_ay, w_ox, w_oy, w_sx, w_sy;

    function automatic logic signed [c_aw2-1:0] f_clamp(input logic signed [c_aw2-1:0] v);
        if (v > c_clamp_hi) return c_clamp_hi;
        if (v < c_clamp_lo) return c_clamp_lo;
        return v;
    endfunction

    function automatic logic signed [c_aw2-1:0] f_sat(input logic signed [c_aw2-1:0] v);
        if (v > c_sat_hi) return c_sat_hi;
        if (v < c_sat_lo) return c_sat_lo;
        return v;
    endfunction

    // Spare packet bits (3, 6, 7 of each channel) carry nothing we decode.
    assign w_unused = ^ps2_mouse;
    assign w_rd     = sel & ~r_old_sel_q;

    always_comb begin
        w_dx = '0; w_dy = '0; w_ax = '0; w_ay = '0;
        w_ox = '0; w_oy = '0; w_sx = '0; w_sy = '0;
        for (int n = 0; n < NCH; n++) begin
            w_tog[n]   = ps2_mouse[25*n+24];
            w_pkt[n]   = w_tog[n] ^ r_old_tog_q[n];
            w_btn_d[n] = w_pkt[n] ? ps2_mouse[25*n +: 3] : r_btn_q[n];

            w_dx = {{(c_aw2-9){ps2_mouse[25*n+4]}}, ps2_mouse[25*n+4], ps2_mouse[25*n+8 +: 8]};
            // Y is inverted so that downward motion on screen counts positive.
            w_dy = -{{(c_aw2-9){ps2_mouse[25*n+5]}}, ps2_mouse[25*n+5], ps2_mouse[25*n+16 +: 8]};

            w_ax = {{2{r_acc_x_q[n][ACC_W-1]}}, r_acc_x_q[n]};
            w_ay = {{2{r_acc_y_q[n][ACC_W-1]}}, r_acc_y_q[n]};
            w_ox = f_clamp(w_ax);
            w_oy = f_clamp(w_ay);
            w_out_x[n] = 8'(w_ox);
            w_out_y[n] = 8'(w_oy);

            w_sx = w_ax;
            w_sy = w_ay;
            if (w_pkt[n]) begin
                w_sx = w_sx + w_dx;
                w_sy = w_sy + w_dy;
            end
            if (w_rd && (addr == 3'(2 + 2*n))) w_sx = w_sx - w_ox;
            if (w_rd && (addr == 3'(3 + 2*n))) w_sy = w_sy - w_oy;
            w_acc_x_d[n] = ACC_W'(f_sat(w_sx));
            w_acc_y_d[n] = ACC_W'(f_sat(w_sy));
        end
    end

    generate
        if (NCH > 1) begin : g_ch1
            assign w_btn1 = r_btn_q[1];
            assign w_x1   = w_out_x[1];
            assign w_y1   = w_out_y[1];
        end else begin : g_no_ch1
            assign w_btn1 = 3'b000;
            assign w_x1   = 8'h00;
            assign w_y1   = 8'h00;
        end
    endgenerate

    always_comb begin
        w_dout_d = r_dout_q;
        if (!sel) begin
            w_dout_d = 8'hFF;
        end else if (w_rd) begin
            case (addr)
                3'd0:    w_dout_d = {1'b0, r_btn_q[0], 4'b0000};
                3'd1:    w_dout_d = {1'b0, w_btn1, 4'b0000};
                3'd2:    w_dout_d = w_out_x[0];
                3'd3:    w_dout_d = w_out_y[0];
                3'd4:    w_dout_d = w_x1;
                3'd5:    w_dout_d = w_y1;
                default: w_dout_d = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        // Toggle history tracks the live input even in reset, so no stale packet fires on release.
        r_old_tog_q <= w_tog;
        if (reset) begin
            for (int n = 0; n < NCH; n++) begin
                r_acc_x_q[n] <= '0;
                r_acc_y_q[n] <= '0;
                r_btn_q[n]   <= '0;
            end
            r_old_sel_q <= 1'b0;
            r_dout_q    <= 8'hFF;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                r_acc_x_q[n] <= w_acc_x_d[n];
                r_acc_y_q[n] <= w_acc_y_d[n];
                r_btn_q[n]   <= w_btn_d[n];
            end
            r_old_sel_q <= sel;
            r_dout_q    <= w_dout_d;
        end
    end

    assign dout = r_dout_q;

endmodule

`default_nettype wire
